rf_write_arbiter: RTL

Arbitrates the register file's single write port between two writeback sources. Source A is the pipeline's in-order ALU writeback and cannot be stalled. Source B is the long-latency writeback (load / multiply), which uses a valid/ready handshake and is buffered in a small FIFO. The block drives the register file write port (we3/wa3/wd3) and exports a pending-register mask so the hazard unit can stall reads of registers whose writes are still buffered.

---
 rtl/rf_write_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: unstallable ALU writeback (A) has priority,
// long-latency writeback (B) is buffered in a small FIFO with a pending-register mask.
module rf_write_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [3:0]               a_addr,
  input  logic [31:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [3:0]               b_addr,
  input  logic [31:0]              b_data,
  output logic                     we3,
  output logic [3:0]               wa3,
  output logic [31:0]              wd3,
  output logic [14:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [3:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic        eff_a;
  logic        eff_b;
  logic        empty;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        sel_we;
  logic [3:0]  sel_addr;
  logic [31:0] sel_data;

  assign b_ready = reset & (count < FULL);
  assign eff_a   = a_valid & (a_addr != 4'hF);
  assign eff_b   = b_valid & b_ready & (b_addr != 4'hF);
  assign empty   = (count == '0);
  // A is younger than a same-cycle B, so a matching B is simply dropped
  assign push    = eff_b & ~bypass & ~(eff_a & (b_addr == a_addr));

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = a_addr;
    sel_data = a_data;
    pop      = 1'b0;
    bypass   = 1'b0;
    if (eff_a) begin
      sel_we = 1'b1;
    end else if (!empty) begin
      pop      = 1'b1;
      sel_we   = live[rd_ptr];
      sel_addr = fifo_addr[rd_ptr];
      sel_data = fifo_data[rd_ptr];
    end else if (eff_b) begin
      bypass   = 1'b1;
      sel_we   = 1'b1;
      sel_addr = b_addr;
      sel_data = b_data;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned r = 0; r < 15; r++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (live[i] && (fifo_addr[i] == 4'(r))) pend_mask[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= b_addr;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we3    <= 1'b0;
      wa3    <= '0;
      wd3    <= '0;
      live   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      we3 <= sel_we;
      if (sel_we) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
      // kill clears live only; killed slots still occupy count until popped
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (eff_a && (fifo_addr[i] == a_addr)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + 1'b1;
      end
      if (push) begin
        live[wr_ptr] <= 1'b1;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
